// File: rtl/lbist_pkg.sv
// Shared types and constants for the logic-BIST pattern generator.
package lbist_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        CAPTURE = 3'd2,
        UNLOAD  = 3'd3,
        DONE    = 3'd4
    } lbist_state_e;

    localparam logic [31:0] LBIST_POLY = 32'hA300_0000;
    localparam logic [31:0] LBIST_SEED = 32'h0000_03E8;

    // Second LFSR tap feeding output bit i of the phase shifter; the first tap is i mod w.
    // The 2*floor(i/w) term gives every w-wide slice of the bus a different tap spacing.
    function automatic int ps_idx(input int i, input int w);
        return (i + 1 + 2 * (i / w)) % w;
    endfunction

endpackage

// File: rtl/lbist_lfsr.sv
// Galois right-shift LFSR with synchronous seed load and advance enable.
module lbist_lfsr
    import lbist_pkg::*;
#(
    parameter int             W    = 32,
    parameter logic [W-1:0]   POLY = W'(LBIST_POLY),
    parameter logic [W-1:0]   SEED = W'(LBIST_SEED)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         adv,
    output logic [W-1:0] q
);

    // An all-zero seed would lock the register at zero forever, so use 1 instead.
    localparam logic [W-1:0] SEED_EFF = (SEED == {W{1'b0}}) ? {{(W-1){1'b0}}, 1'b1} : SEED;

    logic [W-1:0] step_s;

    // Next value: shift right, fold the feedback mask in when a 1 falls out.
    always_comb begin
        step_s = {1'b0, q[W-1:1]} ^ (q[0] ? POLY : {W{1'b0}});
    end

    // State register: reset and load both restore the seed; load outranks advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= SEED_EFF;
        end else if (load) begin
            q <= SEED_EFF;
        end else if (adv) begin
            q <= step_s;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/lbist_tpg.sv
// Logic-BIST test pattern generator: LFSR + phase shifter + shift/capture/unload sequencer.
module lbist_tpg
    import lbist_pkg::*;
#(
    parameter int           N          = 128,
    parameter int           W          = 32,
    parameter logic [W-1:0] POLY       = W'(LBIST_POLY),
    parameter logic [W-1:0] SEED       = W'(LBIST_SEED),
    parameter int           CHAIN_LEN  = 32,
    parameter int           N_PATTERNS = 1000
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic                                abort,
    output logic [N-1:0]                        dout,
    output logic                                scan_en,
    output logic                                misr_en,
    output logic                                busy,
    output logic                                done,
    output logic [$clog2(N_PATTERNS+1)-1:0]     pattern_cnt
);

    localparam int PCW = $clog2(N_PATTERNS + 1);
    localparam int SCW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

    lbist_state_e   state_r, state_s;
    logic [SCW-1:0] shift_cnt_r, shift_cnt_s;
    logic [PCW-1:0] pattern_cnt_r, pattern_cnt_s;
    logic           load_s, adv_s;
    logic           scan_en_s, misr_en_s, busy_s, done_s;
    logic [W-1:0]   l_q_s;

    lbist_lfsr #(.W(W), .POLY(POLY), .SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load_s),
        .adv   (adv_s),
        .q     (l_q_s)
    );

    // Phase shifter: each output bit XORs two distinct LFSR taps.
    for (genvar i = 0; i < N; i++) begin : g_ps
        assign dout[i] = l_q_s[i % W] ^ l_q_s[ps_idx(i, W)];
    end

    assign pattern_cnt = pattern_cnt_r;

    // Next-state, counter and LFSR-control decode; abort overrides everything.
    always_comb begin
        state_s       = state_r;
        shift_cnt_s   = shift_cnt_r;
        pattern_cnt_s = pattern_cnt_r;
        load_s        = 1'b0;
        adv_s         = 1'b0;
        if (abort) begin
            state_s       = IDLE;
            shift_cnt_s   = {SCW{1'b0}};
            pattern_cnt_s = {PCW{1'b0}};
            load_s        = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    load_s = 1'b1;
                    if (start) begin
                        state_s       = SHIFT;
                        shift_cnt_s   = {SCW{1'b0}};
                        pattern_cnt_s = {PCW{1'b0}};
                    end else begin
                        state_s = IDLE;
                    end
                end
                SHIFT: begin
                    adv_s = 1'b1;
                    if (shift_cnt_r == SCW'(CHAIN_LEN - 1)) begin
                        state_s     = CAPTURE;
                        shift_cnt_s = {SCW{1'b0}};
                    end else begin
                        shift_cnt_s = shift_cnt_r + SCW'(1'b1);
                    end
                end
                CAPTURE: begin
                    pattern_cnt_s = pattern_cnt_r + PCW'(1'b1);
                    if (pattern_cnt_s == PCW'(N_PATTERNS)) begin
                        state_s = UNLOAD;
                    end else begin
                        state_s = SHIFT;
                    end
                end
                UNLOAD: begin
                    adv_s = 1'b1;
                    if (shift_cnt_r == SCW'(CHAIN_LEN - 1)) begin
                        state_s     = DONE;
                        shift_cnt_s = {SCW{1'b0}};
                    end else begin
                        shift_cnt_s = shift_cnt_r + SCW'(1'b1);
                    end
                end
                DONE: begin
                    if (start) begin
                        state_s       = SHIFT;
                        shift_cnt_s   = {SCW{1'b0}};
                        pattern_cnt_s = {PCW{1'b0}};
                        load_s        = 1'b1;
                    end else begin
                        state_s = DONE;
                    end
                end
                default: begin
                    state_s       = IDLE;
                    shift_cnt_s   = {SCW{1'b0}};
                    pattern_cnt_s = {PCW{1'b0}};
                    load_s        = 1'b1;
                end
            endcase
        end
    end

    // Flag decode from the upcoming state so the registered flags line up with it.
    always_comb begin
        scan_en_s = (state_s == SHIFT) || (state_s == UNLOAD);
        misr_en_s = ((state_s == SHIFT) && (pattern_cnt_s != {PCW{1'b0}})) || (state_s == UNLOAD);
        busy_s    = (state_s == SHIFT) || (state_s == CAPTURE) || (state_s == UNLOAD);
        done_s    = (state_s == DONE);
    end

    // Sequencer registers and registered output flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            shift_cnt_r   <= {SCW{1'b0}};
            pattern_cnt_r <= {PCW{1'b0}};
            scan_en       <= 1'b0;
            misr_en       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state_r       <= state_s;
            shift_cnt_r   <= shift_cnt_s;
            pattern_cnt_r <= pattern_cnt_s;
            scan_en       <= scan_en_s;
            misr_en       <= misr_en_s;
            busy          <= busy_s;
            done          <= done_s;
        end
    end

endmodule
